// File: rtl/vga_bg_scroll_addr_if.sv
// Bundles the offset PIO, VGA raster and background-address signals of vga_bg_scroll_addr.
// master drives offset/raster (PIO + VGA controller side); slave is the address generator.
interface vga_bg_scroll_addr_if #(
  parameter int ADDR_W = 17
);
  logic [31:0]       offset_in;
  logic              vs_n;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic              pix_valid;
  logic [ADDR_W-1:0] bg_addr;
  logic              addr_valid;
  logic [15:0]       cur_offset;
  logic              offset_err;

  modport master (
    output offset_in, vs_n, draw_x, draw_y, pix_valid,
    input  bg_addr, addr_valid, cur_offset, offset_err
  );

  modport slave (
    input  offset_in, vs_n, draw_x, draw_y, pix_valid,
    output bg_addr, addr_valid, cur_offset, offset_err
  );
endinterface

// File: rtl/vga_bg_scroll_addr.sv
// Raster-to-background-address generator with a frame-shadowed vertical scroll offset.
// Optional feature macro: BG_AUTOSCROLL_EN (per-frame auto-scroll, software offset becomes a trim).
module vga_bg_scroll_addr #(
  parameter int BG_W        = 320,
  parameter int BG_H        = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int AUTO_STEP   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vga_bg_scroll_addr_if.slave  bus
);

  // Pixel stream is valid-only: pix_valid qualifies draw_x/draw_y in the cycle it is high,
  // addr_valid qualifies bg_addr exactly two cycles later; there is no ready/backpressure.

  function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = 17'(a) + 17'(b);
    return 16'((s >= 17'(BG_H)) ? s - 17'(BG_H) : s);
  endfunction

  logic        vs_n_q;
  logic        frame_start;
  logic        off_ok;
  logic [15:0] shadow_q;
  logic [15:0] shadow_nxt;
  logic [15:0] cur_q;
  logic [15:0] cur_nxt;
  logic        err_q;
  logic        unused_bits;

  assign frame_start = vs_n_q & ~bus.vs_n;
  assign off_ok      = bus.offset_in[15:0] < 16'(BG_H);
  assign shadow_nxt  = off_ok ? bus.offset_in[15:0] : shadow_q;
  assign unused_bits = ^bus.offset_in[31:16];

`ifdef BG_AUTOSCROLL_EN
  logic [15:0] auto_q;
  logic [15:0] auto_nxt;

  assign auto_nxt = wrap_add(auto_q, 16'(AUTO_STEP));
  assign cur_nxt  = wrap_add(shadow_nxt, auto_nxt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_q <= '0;
    end else if (frame_start) begin
      auto_q <= auto_nxt;
    end
  end
`else
  localparam int unused_auto_step = AUTO_STEP;
  assign cur_nxt = shadow_nxt;
`endif

  // Offset is only sampled at the frame boundary so a frame never mixes two offsets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_n_q   <= 1'b1;
      shadow_q <= '0;
      cur_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      vs_n_q <= bus.vs_n;
      if (frame_start) begin
        shadow_q <= shadow_nxt;
        cur_q    <= cur_nxt;
        if (!off_ok) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Stage 1: texel coordinates and unwrapped row sum.
  logic        v_s1;
  logic [9:0]  tx_s1;
  logic [16:0] sum_s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_s1   <= 1'b0;
      tx_s1  <= '0;
      sum_s1 <= '0;
    end else begin
      v_s1   <= bus.pix_valid;
      tx_s1  <= bus.draw_x >> SCALE_SHIFT;
      sum_s1 <= 17'(bus.draw_y >> SCALE_SHIFT) + 17'(cur_q);
    end
  end

  // Stage 2: single conditional wrap is enough since both operands are below BG_H.
  logic [16:0]       row_s2;
  logic [ADDR_W-1:0] addr_nxt;
  logic              av_q;
  logic [ADDR_W-1:0] addr_q;

  assign row_s2   = (sum_s1 >= 17'(BG_H)) ? sum_s1 - 17'(BG_H) : sum_s1;
  assign addr_nxt = ADDR_W'(32'(row_s2) * 32'(BG_W) + 32'(tx_s1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      av_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      av_q <= v_s1;
      if (v_s1) begin
        addr_q <= addr_nxt;
      end
    end
  end

  assign bus.bg_addr    = addr_q;
  assign bus.addr_valid = av_q;
  assign bus.cur_offset = cur_q;
  assign bus.offset_err = err_q;

endmodule

// File: tb/tb_vga_bg_scroll_addr.sv
// Randomised bench for vga_bg_scroll_addr against a frame-level offset model and address scoreboard.
// Optional feature macro: BG_AUTOSCROLL_EN (must match the RTL build).
module tb_vga_bg_scroll_addr;
  localparam int BG_W = 320;
  localparam int BG_H = 240;
  localparam int SS   = 1;
  localparam int AW   = 17;
  localparam int STEP = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_bg_scroll_addr_if #(.ADDR_W(AW)) bus ();

  vga_bg_scroll_addr #(
    .BG_W(BG_W), .BG_H(BG_H), .SCALE_SHIFT(SS), .ADDR_W(AW), .AUTO_STEP(STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_sw, m_auto, m_cur;
  bit  m_err, m_prev_vs, m_v1, m_av;
  int  m_tx, m_ty, m_addr;
  logic [AW-1:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sw = 0; m_auto = 0; m_cur = 0; m_err = 0;
      m_prev_vs = 1; m_v1 = 0; m_av = 0;
      exp_q.delete();
    end else begin
      m_av = m_v1;
      m_v1 = bus.pix_valid;
      if (bus.pix_valid) begin
        m_tx   = int'(bus.draw_x) >> SS;
        m_ty   = int'(bus.draw_y) >> SS;
        m_addr = ((m_ty + m_cur) % BG_H) * BG_W + m_tx;
        exp_q.push_back(AW'(m_addr));
      end
      if (m_prev_vs && !bus.vs_n) begin
        if (int'(bus.offset_in[15:0]) < BG_H) m_sw = int'(bus.offset_in[15:0]);
        else m_err = 1;
`ifdef BG_AUTOSCROLL_EN
        m_auto = (m_auto + STEP) % BG_H;
        m_cur  = (m_sw + m_auto) % BG_H;
`else
        m_cur  = m_sw;
`endif
      end
      m_prev_vs = bus.vs_n;
    end
  end

  // ---------------- scoreboard compare ----------------
  int m_last = 0;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_last = 0;
    end else begin
      check("addr_valid", bus.addr_valid, m_av);
      if (m_av && bus.addr_valid) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e_addr = exp_q.pop_front();
          check("bg_addr", bus.bg_addr, e_addr);
          m_last = int'(e_addr);
        end
      end else if (!m_av) begin
        check("bg_addr_hold", bus.bg_addr, m_last);
      end
      check("cur_offset", bus.cur_offset, m_cur);
      check("offset_err", bus.offset_err, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_off();
    logic [15:0] lo;
    lo = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(BG_H, 65535))
                                     : 16'($urandom_range(0, BG_H - 1));
    return {16'($urandom), lo};
  endfunction

  task automatic boundary(input int off);
    bus.offset_in = {16'($urandom), 16'(off)};
    bus.vs_n = 1'b0;
    tick();
    bus.vs_n = 1'b1;
  endtask

  task automatic pix(input int x, input int y);
    bus.draw_x = 10'(x);
    bus.draw_y = 10'(y);
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    tick();
  endtask

  task automatic random_run(input int cycles);
    int frame_cnt;
    int vs_low;
    frame_cnt = $urandom_range(20, 60);
    vs_low = 0;
    for (int i = 0; i < cycles; i++) begin
      bus.pix_valid = 1'($urandom_range(0, 1));
      bus.draw_x = 10'($urandom_range(0, 639));
      bus.draw_y = 10'($urandom_range(0, 479));
      if (frame_cnt > 0) begin
        frame_cnt--;
        bus.vs_n = 1'b1;
        if ($urandom_range(0, 15) == 0) bus.offset_in = rand_off();
      end else begin
        bus.vs_n = 1'b0;
        if (vs_low == 0) vs_low = $urandom_range(1, 4);
        vs_low--;
        if (vs_low == 0) frame_cnt = $urandom_range(20, 60);
      end
      tick();
    end
    bus.vs_n = 1'b1;
    bus.pix_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.offset_in = '0;
    bus.vs_n = 1'b1;
    bus.draw_x = '0;
    bus.draw_y = '0;
    bus.pix_valid = 1'b0;
    repeat (3) tick();
    check("rst_bg_addr", bus.bg_addr, 0);
    check("rst_addr_valid", bus.addr_valid, 0);
    check("rst_cur_offset", bus.cur_offset, 0);
    check("rst_offset_err", bus.offset_err, 0);
    reset_n = 1'b1;
    tick();

`ifdef BG_AUTOSCROLL_EN
    boundary(0);
    check("auto_first_frame", bus.cur_offset, 1);
    tick();
    for (int f = 1; f < BG_H; f++) begin
      boundary(0);
      tick();
    end
    check("auto_wrap_240", bus.cur_offset, 0);
`else
    pix(20, 10);
    check("lit_addr_1610", bus.bg_addr, 1610);
    check("lit_valid_1610", bus.addr_valid, 1);

    bus.offset_in = 32'd100;
    repeat (3) tick();
    check("lit_mid_frame_hold", bus.cur_offset, 0);
    boundary(100);
    check("lit_cur_100", bus.cur_offset, 100);
    pix(40, 300);
    check("lit_addr_3220", bus.bg_addr, 3220);

    boundary(239);
    check("lit_cur_239", bus.cur_offset, 239);
    pix(0, 478);
    check("lit_addr_wrap", bus.bg_addr, 238 * 320);

    boundary(240);
    check("lit_reject_cur", bus.cur_offset, 239);
    check("lit_reject_err", bus.offset_err, 1);
    tick();
    boundary(5);
    check("lit_after_err_cur", bus.cur_offset, 5);
    check("lit_err_sticky", bus.offset_err, 1);
    tick();
`endif

    random_run(3000);

    // Async reset in the middle of a valid burst.
    bus.pix_valid = 1'b1;
    bus.draw_x = 10'($urandom_range(0, 639));
    bus.draw_y = 10'($urandom_range(0, 479));
    repeat (3) tick();
    check("pre_reset_valid", bus.addr_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_bg_addr", bus.bg_addr, 0);
    check("async_rst_addr_valid", bus.addr_valid, 0);
    check("async_rst_cur_offset", bus.cur_offset, 0);
    check("async_rst_offset_err", bus.offset_err, 0);
    bus.pix_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    random_run(400);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
